// File: rtl/bounce_box_gen.sv
// Pixel source feeding the VGA timing core: background gradient plus a
// solid box that bounces inside [XMIN,XMAX) x [YMIN,YMAX). The box moves
// once per frame, on the first cycle the scan reaches (0, UPDATE_LINE).
// That line is outside the visible rows, so the box never tears.
// Pixel output is registered with exactly one cycle of latency.
module bounce_box_gen #(
    parameter int XMIN        = 16,
    parameter int XMAX        = 656,
    parameter int YMIN        = 10,
    parameter int YMAX        = 490,
    parameter int BOX_W       = 32,
    parameter int BOX_H       = 24,
    parameter int SPEED       = 2,
    parameter int X0          = 100,
    parameter int Y0          = 100,
    parameter int UPDATE_LINE = 500
) (
    input  logic        clk_25_175,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        run,
    output logic [11:0] pixstream,
    output logic [7:0]  frame_cnt,
    output logic        bounce
);

    // All position arithmetic is 11 bits wide, so x+BOX_W and x+SPEED
    // cannot overflow.
    localparam logic [10:0] L_XMIN  = 11'(XMIN);
    localparam logic [10:0] L_YMIN  = 11'(YMIN);
    localparam logic [10:0] L_XLIM  = 11'(XMAX - BOX_W);
    localparam logic [10:0] L_YLIM  = 11'(YMAX - BOX_H);
    localparam logic [10:0] L_BOX_W = 11'(BOX_W);
    localparam logic [10:0] L_BOX_H = 11'(BOX_H);
    localparam logic [10:0] L_SPEED = 11'(SPEED);
    localparam logic [10:0] L_X0    = 11'(X0);
    localparam logic [10:0] L_Y0    = 11'(Y0);
    localparam logic [9:0]  L_UPD   = 10'(UPDATE_LINE);

    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_xdir;        // 1 = moving right
    logic        r_ydir;        // 1 = moving down
    logic        r_upd_prev;
    logic [7:0]  r_frame_cnt;
    logic [11:0] r_pix;
    logic        r_bounce;

    logic        w_upd_now;
    logic        w_event;
    logic [10:0] w_h11;
    logic [10:0] w_v11;
    logic        w_inbox;
    logic [12:0] w_xs;          // {hit, dir, pos}
    logic [12:0] w_ys;

    // One axis step. Returns {hit, new_dir, new_pos}. Landing exactly on
    // a bound is not a hit; the reflection happens on the next step.
    function automatic logic [12:0] axis_step(
        input logic [10:0] pos,
        input logic        dir,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        logic [12:0] res;
        if (dir) begin
            if (pos + L_SPEED > hi) res = {1'b1, 1'b0, hi};
            else                    res = {1'b0, 1'b1, 11'(pos + L_SPEED)};
        end else begin
            if (pos < lo + L_SPEED) res = {1'b1, 1'b1, lo};
            else                    res = {1'b0, 1'b0, 11'(pos - L_SPEED)};
        end
        return res;
    endfunction

    assign w_upd_now = (hpos == 10'd0) && (vpos == L_UPD);
    // The event fires only on the rising edge of w_upd_now, so a stalled
    // scan counter cannot produce a second event in the same frame.
    assign w_event   = w_upd_now && !r_upd_prev;
    assign w_h11     = {1'b0, hpos};
    assign w_v11     = {1'b0, vpos};
    assign w_inbox   = (w_h11 >= r_x) && (w_h11 < r_x + L_BOX_W) &&
                       (w_v11 >= r_y) && (w_v11 < r_y + L_BOX_H);
    assign w_xs      = axis_step(r_x, r_xdir, L_XMIN, L_XLIM);
    assign w_ys      = axis_step(r_y, r_ydir, L_YMIN, L_YLIM);

    // Per-frame motion, frame counter and the single-cycle bounce pulse.
    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            r_x         <= L_X0;
            r_y         <= L_Y0;
            r_xdir      <= 1'b1;
            r_ydir      <= 1'b1;
            r_upd_prev  <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_bounce    <= 1'b0;
        end else begin
            r_upd_prev <= w_upd_now;
            r_bounce   <= 1'b0;
            if (w_event) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                if (run) begin
                    r_x      <= w_xs[10:0];
                    r_xdir   <= w_xs[11];
                    r_y      <= w_ys[10:0];
                    r_ydir   <= w_ys[11];
                    r_bounce <= w_xs[12] | w_ys[12];
                end
            end
        end
    end

    // Registered pixel word: box colour follows frame_cnt, background is
    // a coarse gradient built from the scan position.
    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            r_pix <= 12'h000;
        end else if (w_inbox) begin
            r_pix <= {4'hF, ~r_frame_cnt[7:4], r_frame_cnt[7:4]};
        end else begin
            r_pix <= {4'h2, vpos[8:5], hpos[8:5]};
        end
    end

    assign pixstream = r_pix;
    assign frame_cnt = r_frame_cnt;
    assign bounce    = r_bounce;

endmodule
